// File: rtl/md_step_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : md_step_sequencer_if
// Description : Phase handshake bundle between the MD step sequencer and the
//               two compute phases (force phase and motion-update phase).
//               master : sequencer side (drives READY pulses and buffer select)
//               slave  : phase-engine side (drives DONE levels)
// Signals     : CTL_READY         - start pulse to the force phase
//               CTL_DOUBLE_BUFFER - position/velocity buffer half for the step
//               CTL_DONE          - force-phase completion level
//               P2_READY          - start pulse to the motion-update phase
//               P2_DONE           - motion-update completion level
// Revision    : 1.0 - initial release
// ============================================================================
interface md_step_sequencer_if;
  logic CTL_READY;
  logic CTL_DOUBLE_BUFFER;
  logic CTL_DONE;
  logic P2_READY;
  logic P2_DONE;

  modport master (
    output CTL_READY,
    output CTL_DOUBLE_BUFFER,
    output P2_READY,
    input  CTL_DONE,
    input  P2_DONE
  );

  modport slave (
    input  CTL_READY,
    input  CTL_DOUBLE_BUFFER,
    input  P2_READY,
    output CTL_DONE,
    output P2_DONE
  );
endinterface
`default_nettype wire

// File: rtl/md_step_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : md_step_sequencer
// Description : Runs n_steps molecular-dynamics timesteps. Each step issues a
//               READY pulse to the force phase, waits for its DONE rising
//               edge, does the same for the motion-update phase, then swaps
//               the double-buffer half and counts the step. Each wait phase
//               is guarded by a timeout that parks the sequencer in a sticky
//               FAULT state until reset.
// Ports       : clk        - rising-edge clock
//               reset      - synchronous active-high reset
//               start      - one-cycle run request (honoured only in IDLE)
//               n_steps    - timestep count, sampled on an accepted start
//               abort      - cancel the current run
//               phase      - phase handshake bundle (master side)
//               busy       - run in progress
//               done       - one-cycle pulse on normal completion
//               fault      - sticky phase timeout
//               step_count - steps completed in current / most recent run
// Parameters  : TIMEOUT_CYCLES - max wait cycles per phase before fault
//               READY_CYCLES   - READY pulse width in cycles (minimum 1)
// Revision    : 1.0 - initial release
// ============================================================================
module md_step_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 1048576,
  parameter int unsigned READY_CYCLES   = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [31:0]                n_steps,
  input  logic                       abort,
  md_step_sequencer_if.master        phase,
  output logic                       busy,
  output logic                       done,
  output logic                       fault,
  output logic [31:0]                step_count
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    P1_GO   = 3'd1,
    P1_WAIT = 3'd2,
    P2_GO   = 3'd3,
    P2_WAIT = 3'd4,
    SWAP    = 3'd5,
    FINISH  = 3'd6,
    FAULT   = 3'd7
  } state_t;

  // Terminal values of the shared phase counter: it counts READY cycles in a
  // _GO state and wait cycles in a _WAIT state, restarting at 0 in between.
  localparam logic [31:0] READY_LAST   = 32'(READY_CYCLES - 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [31:0] n_target;
  logic [31:0] phase_cnt;
  logic        ctl_ready_r;
  logic        p2_ready_r;
  logic        dbuf_r;
  logic        ctl_done_q;
  logic        p2_done_q;
  logic        ctl_done_rise;
  logic        p2_done_rise;

  // DONE inputs are levels; only a low->high transition counts, so a level
  // left high by the previous step (or arriving during _GO) is not mistaken
  // for completion.
  assign ctl_done_rise = phase.CTL_DONE & ~ctl_done_q;
  assign p2_done_rise  = phase.P2_DONE  & ~p2_done_q;

  assign phase.CTL_READY         = ctl_ready_r;
  assign phase.P2_READY          = p2_ready_r;
  assign phase.CTL_DOUBLE_BUFFER = dbuf_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      n_target    <= 32'd0;
      phase_cnt   <= 32'd0;
      ctl_ready_r <= 1'b0;
      p2_ready_r  <= 1'b0;
      dbuf_r      <= 1'b0;
      ctl_done_q  <= 1'b0;
      p2_done_q   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      fault       <= 1'b0;
      step_count  <= 32'd0;
    end else begin
      ctl_done_q <= phase.CTL_DONE;
      p2_done_q  <= phase.P2_DONE;
      done       <= 1'b0;

      if (state == IDLE) begin
        // abort in the same cycle suppresses the start request
        if (start && !abort) begin
          step_count <= 32'd0;
          if (n_steps == 32'd0) begin
            state <= FINISH;
          end else begin
            n_target    <= n_steps;
            busy        <= 1'b1;
            ctl_ready_r <= 1'b1;
            phase_cnt   <= 32'd0;
            state       <= P1_GO;
          end
        end
      end else if (state == FAULT) begin
        // parked until reset
        state <= FAULT;
      end else if (abort) begin
        // step_count and the buffer select keep their values
        ctl_ready_r <= 1'b0;
        p2_ready_r  <= 1'b0;
        busy        <= 1'b0;
        state       <= IDLE;
      end else begin
        case (state)
          P1_GO: begin
            if (phase_cnt == READY_LAST) begin
              ctl_ready_r <= 1'b0;
              phase_cnt   <= 32'd0;
              state       <= P1_WAIT;
            end else begin
              phase_cnt <= phase_cnt + 32'd1;
            end
          end

          P1_WAIT: begin
            // a DONE edge wins over a coincident timeout
            if (ctl_done_rise) begin
              p2_ready_r <= 1'b1;
              phase_cnt  <= 32'd0;
              state      <= P2_GO;
            end else if (phase_cnt == TIMEOUT_LAST) begin
              fault       <= 1'b1;
              busy        <= 1'b0;
              ctl_ready_r <= 1'b0;
              p2_ready_r  <= 1'b0;
              state       <= FAULT;
            end else begin
              phase_cnt <= phase_cnt + 32'd1;
            end
          end

          P2_GO: begin
            if (phase_cnt == READY_LAST) begin
              p2_ready_r <= 1'b0;
              phase_cnt  <= 32'd0;
              state      <= P2_WAIT;
            end else begin
              phase_cnt <= phase_cnt + 32'd1;
            end
          end

          P2_WAIT: begin
            if (p2_done_rise) begin
              state <= SWAP;
            end else if (phase_cnt == TIMEOUT_LAST) begin
              fault       <= 1'b1;
              busy        <= 1'b0;
              ctl_ready_r <= 1'b0;
              p2_ready_r  <= 1'b0;
              state       <= FAULT;
            end else begin
              phase_cnt <= phase_cnt + 32'd1;
            end
          end

          SWAP: begin
            step_count <= step_count + 32'd1;
            dbuf_r     <= ~dbuf_r;
            if ((step_count + 32'd1) == n_target) begin
              state <= FINISH;
            end else begin
              ctl_ready_r <= 1'b1;
              phase_cnt   <= 32'd0;
              state       <= P1_GO;
            end
          end

          FINISH: begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire
